// File: rtl/bnn_pkg.sv
// Shared definitions for the BNN inference pipeline: the state bus encoding
// seen by every layer block, image geometry and result width.
package bnn_pkg;

  // State bus encoding, decoded directly by the layer blocks.
  localparam logic [2:0] S_IDLE    = 3'b000;
  localparam logic [2:0] S_LOAD    = 3'b001;
  localparam logic [2:0] S_LAYER_1 = 3'b010;
  localparam logic [2:0] S_LAYER_2 = 3'b011;
  localparam logic [2:0] S_LAYER_3 = 3'b100;
  localparam logic [2:0] S_RESULT  = 3'b101;
  localparam logic [2:0] S_ERROR   = 3'b111;

  // 784 binary pixels packed eight per byte.
  localparam int IMG_BEATS = 98;
  localparam int BEAT_W    = 7;
  localparam int CLASS_W   = 4;

  typedef enum logic [2:0] {
    ST_IDLE    = S_IDLE,
    ST_LOAD    = S_LOAD,
    ST_LAYER_1 = S_LAYER_1,
    ST_LAYER_2 = S_LAYER_2,
    ST_LAYER_3 = S_LAYER_3,
    ST_RESULT  = S_RESULT,
    ST_ERROR   = S_ERROR
  } seq_state_e;

endpackage

// File: rtl/bnn_watchdog.sv
// Per-state cycle counter. Cleared on every state change, counts while
// enabled, and stops at its last value so it can never wrap back to zero.
module bnn_watchdog #(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int CW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] count;

  // Count cycles spent in the current state; hold once the limit is reached.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (en && !expire) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == CW'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/bnn_layer_sequencer.sv
// Top-level controller: loads a binarised image into the image buffer, walks
// the shared state bus through the three layers, captures the class result,
// and watches each layer for a hang.
//
// Handshake: an image byte is accepted on any rising edge where
// pix_valid && pix_ready; pix_ready is high exactly while in LOAD, and the
// accepted byte is written to the buffer in that same cycle.
module bnn_layer_sequencer
  import bnn_pkg::*;
#(
  parameter int TIMEOUT_CYC = 1024
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic               pix_valid,
  input  logic [7:0]         pix_data,
  output logic               pix_ready,
  output logic               img_wr_en,
  output logic [BEAT_W-1:0]  img_wr_addr,
  output logic [7:0]         img_wr_data,
  output logic [2:0]         state,
  output logic               layer_clr,
  input  logic               l1_done,
  input  logic               l2_done,
  input  logic               l3_done,
  input  logic [CLASS_W-1:0] class_in,
  output logic [CLASS_W-1:0] class_out,
  output logic               class_valid,
  output logic               busy,
  output logic               err
);

  seq_state_e        state_q;
  seq_state_e        state_d;
  logic [BEAT_W-1:0] beat;
  logic              accept;
  logic              last_beat;
  logic              in_layer;
  logic              wd_expire;

  assign accept    = (state_q == ST_LOAD) && pix_valid;
  assign last_beat = (beat == BEAT_W'(IMG_BEATS - 1));
  assign in_layer  = (state_q == ST_LAYER_1) || (state_q == ST_LAYER_2) ||
                     (state_q == ST_LAYER_3);

  // Next-state logic; abort overrides every other transition.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (start) state_d = ST_LOAD;
      ST_LOAD:    if (accept && last_beat) state_d = ST_LAYER_1;
      ST_LAYER_1: if (l1_done) state_d = ST_LAYER_2;
                  else if (wd_expire) state_d = ST_ERROR;
      ST_LAYER_2: if (l2_done) state_d = ST_LAYER_3;
                  else if (wd_expire) state_d = ST_ERROR;
      ST_LAYER_3: if (l3_done) state_d = ST_RESULT;
                  else if (wd_expire) state_d = ST_ERROR;
      ST_RESULT:  state_d = ST_IDLE;
      ST_ERROR:   state_d = ST_ERROR;
      default:    state_d = ST_IDLE;
    endcase
    if (abort) state_d = ST_IDLE;
  end

  // State register plus the one-cycle clear pulse for the first LOAD cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      layer_clr <= 1'b0;
    end else begin
      state_q   <= state_d;
      layer_clr <= (state_q == ST_IDLE) && (state_d == ST_LOAD);
    end
  end

  // Image byte counter; returns to zero after the last byte or on abort.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      beat <= '0;
    end else if (accept) begin
      beat <= last_beat ? '0 : beat + 1'b1;
    end
  end

  // Class capture on the edge that enters RESULT; held until the next result.
  always_ff @(posedge clk) begin
    if (rst) begin
      class_out <= '0;
    end else if (state_q == ST_LAYER_3 && state_d == ST_RESULT) begin
      class_out <= class_in;
    end
  end

  bnn_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    ((state_d != state_q) || abort),
    .en     (in_layer),
    .expire (wd_expire)
  );

  assign state       = state_q;
  assign pix_ready   = (state_q == ST_LOAD);
  assign img_wr_en   = accept;
  assign img_wr_addr = beat;
  assign img_wr_data = accept ? pix_data : 8'h00;
  assign class_valid = (state_q == ST_RESULT);
  assign busy        = (state_q != ST_IDLE) && (state_q != ST_ERROR);
  assign err         = (state_q == ST_ERROR);

endmodule

// File: tb/tb_bnn_layer_sequencer.sv
// Bench for bnn_layer_sequencer: random image bytes, gaps, layer latencies and
// classes, checked against expectations derived from the sequencing rules.
module tb_bnn_layer_sequencer;
  import bnn_pkg::*;

  localparam int TO = 16;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic         pix_valid = 1'b0;
  logic [7:0]   pix_data = 8'h00;
  logic         pix_ready;
  logic         img_wr_en;
  logic [6:0]   img_wr_addr;
  logic [7:0]   img_wr_data;
  logic [2:0]   state;
  logic         layer_clr;
  logic         l1_done = 1'b0;
  logic         l2_done = 1'b0;
  logic         l3_done = 1'b0;
  logic [3:0]   class_in = 4'h0;
  logic [3:0]   class_out;
  logic         class_valid;
  logic         busy;
  logic         err;

  int           n_cmp = 0;
  int           n_bad = 0;
  int           write_cnt = 0;
  logic [3:0]   exp_class = 4'h0;
  logic [14:0]  exp_q[$];

  bnn_layer_sequencer #(.TIMEOUT_CYC(TO)) dut (
    .clk (clk), .rst (rst), .start (start), .abort (abort),
    .pix_valid (pix_valid), .pix_data (pix_data), .pix_ready (pix_ready),
    .img_wr_en (img_wr_en), .img_wr_addr (img_wr_addr),
    .img_wr_data (img_wr_data), .state (state), .layer_clr (layer_clr),
    .l1_done (l1_done), .l2_done (l2_done), .l3_done (l3_done),
    .class_in (class_in), .class_out (class_out),
    .class_valid (class_valid), .busy (busy), .err (err)
  );

  // Clock and global time limit.
  always #5 clk = ~clk;

  initial begin
    #300000;
    $display("FAIL time_limit: simulation did not complete, got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Scoreboard: every buffer write must match the next accepted byte.
  always @(negedge clk) begin
    if (img_wr_en === 1'b1) begin
      write_cnt++;
      if (exp_q.size() == 0) begin
        check("extra_write", {17'h0, img_wr_addr, img_wr_data}, 32'hFFFF_FFFF);
      end else begin
        logic [14:0] e;
        e = exp_q.pop_front();
        check("wr_addr_data", {17'h0, img_wr_addr, img_wr_data}, {17'h0, e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_inference();
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk);
    check("start_to_load", state, S_LOAD);
    check("layer_clr_first", layer_clr, 1);
    check("pix_ready_load", pix_ready, 1);
    check("busy_load", busy, 1);
  endtask

  // gap_mode 0: back-to-back, 1: one beat every third cycle, 2: random gaps.
  task automatic load_image(input int gap_mode, input int n_beats);
    int g;
    write_cnt = 0;
    for (int b = 0; b < n_beats; b++) begin
      g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 2 : int'($urandom_range(0, 2));
      pix_valid = 1'b0;
      for (int k = 0; k < g; k++) begin
        tick();
        @(negedge clk);
        check("load_gap_state", state, S_LOAD);
      end
      pix_valid = 1'b1;
      pix_data  = 8'($urandom);
      exp_q.push_back({7'(b), pix_data});
      tick();
      pix_valid = 1'b0;
      @(negedge clk);
      if (b == 0) check("layer_clr_once", layer_clr, 0);
      if (b == IMG_BEATS - 1) check("load_to_l1", state, S_LAYER_1);
      else check("load_state", state, S_LOAD);
    end
    check("n_writes", write_cnt, n_beats);
  endtask

  task automatic set_done(input int n, input logic v);
    case (n)
      1: l1_done = v;
      2: l2_done = v;
      default: l3_done = v;
    endcase
  endtask

  // Spend delay cycles in layer n (other layers' done flags toggling
  // randomly), then raise its done and check the following state.
  task automatic run_layer(input int n, input int delay, input logic [2:0] cur,
                           input logic [2:0] nxt);
    for (int i = 0; i < delay; i++) begin
      l1_done = (n != 1) && ($urandom_range(0, 1) == 1);
      l2_done = (n != 2) && ($urandom_range(0, 1) == 1);
      l3_done = (n != 3) && ($urandom_range(0, 1) == 1);
      tick();
      @(negedge clk);
      check("layer_wait", state, cur);
    end
    l1_done = 1'b0; l2_done = 1'b0; l3_done = 1'b0;
    set_done(n, 1'b1);
    tick();
    set_done(n, 1'b0);
    @(negedge clk);
    check("layer_advance", state, nxt);
    check("err_low", err, 0);
  endtask

  task automatic finish_result(input logic [3:0] cls);
    check("result_valid", class_valid, 1);
    check("result_class", class_out, cls);
    exp_class = cls;
    tick();
    @(negedge clk);
    check("result_to_idle", state, S_IDLE);
    check("valid_one_cycle", class_valid, 0);
    check("class_held", class_out, exp_class);
    check("busy_idle", busy, 0);
  endtask

  task automatic full_run(input int gap_mode, input int d1, input int d2, input int d3);
    logic [3:0] cls;
    cls = 4'($urandom_range(0, 9));
    start_inference();
    load_image(gap_mode, IMG_BEATS);
    check("pix_ready_l1", pix_ready, 0);
    run_layer(1, d1, S_LAYER_1, S_LAYER_2);
    run_layer(2, d2, S_LAYER_2, S_LAYER_3);
    class_in = cls;
    run_layer(3, d3, S_LAYER_3, S_RESULT);
    finish_result(cls);
  endtask

  initial begin
    // Reset state.
    rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    @(negedge clk);
    check("rst_state", state, S_IDLE);
    check("rst_pix_ready", pix_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_class_out", class_out, 0);
    check("rst_class_valid", class_valid, 0);
    check("rst_layer_clr", layer_clr, 0);

    // Nominal run with class 7, layers done 5 cycles after entry.
    start_inference();
    load_image(0, IMG_BEATS);
    run_layer(1, 5, S_LAYER_1, S_LAYER_2);
    run_layer(2, 5, S_LAYER_2, S_LAYER_3);
    class_in = 4'd7;
    run_layer(3, 5, S_LAYER_3, S_RESULT);
    finish_result(4'd7);

    // Stalled load: one beat every third cycle.
    full_run(1, 2, 3, 4);

    // Timeout in LAYER_2: sixteen cycles there, then ERROR.
    start_inference();
    load_image(2, IMG_BEATS);
    run_layer(1, 3, S_LAYER_1, S_LAYER_2);
    for (int i = 0; i < TO - 1; i++) begin
      tick();
      @(negedge clk);
      check("to_wait_l2", state, S_LAYER_2);
    end
    tick();
    @(negedge clk);
    check("to_error", state, S_ERROR);
    check("to_err_flag", err, 1);
    check("to_busy_low", busy, 0);
    start = 1'b1;
    tick(); tick();
    start = 1'b0;
    @(negedge clk);
    check("error_ignores_start", state, S_ERROR);
    check("err_held", err, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_error_idle", state, S_IDLE);
    check("abort_err_clear", err, 0);
    check("abort_class_kept", class_out, exp_class);

    // Done arriving on the expiry cycle wins over the timeout.
    start_inference();
    load_image(0, IMG_BEATS);
    run_layer(1, TO - 1, S_LAYER_1, S_LAYER_2);
    run_layer(2, 4, S_LAYER_2, S_LAYER_3);
    class_in = 4'd3;
    run_layer(3, 1, S_LAYER_3, S_RESULT);
    finish_result(4'd3);

    // Abort mid-LOAD at beat 40, then a fresh image from address 0.
    start_inference();
    load_image(2, 40);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    check("abort_load_idle", state, S_IDLE);
    check("abort_load_ready", pix_ready, 0);
    check("abort_load_class", class_out, exp_class);
    check("abort_q_empty", exp_q.size(), 0);
    full_run(0, 1, 1, 1);

    // Abort together with start in IDLE stays in IDLE.
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    check("abort_start_idle", state, S_IDLE);
    check("abort_start_no_clr", layer_clr, 0);

    // Reset in the middle of LAYER_2.
    start_inference();
    load_image(0, IMG_BEATS);
    run_layer(1, 2, S_LAYER_1, S_LAYER_2);
    tick(); tick();
    rst = 1'b1;
    tick();
    @(negedge clk);
    check("midrst_state", state, S_IDLE);
    check("midrst_class_out", class_out, 0);
    check("midrst_busy", busy, 0);
    check("midrst_err", err, 0);
    check("midrst_pix_ready", pix_ready, 0);
    check("midrst_wr_en", img_wr_en, 0);
    rst = 1'b0;
    exp_class = 4'h0;
    tick();
    full_run(0, 5, 5, 5);

    // Randomised runs.
    for (int r = 0; r < 3; r++) begin
      full_run(2, int'($urandom_range(0, TO - 1)), int'($urandom_range(0, TO - 1)),
               int'($urandom_range(0, TO - 1)));
    end

    check("final_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
